cpu_sram_arbiter: RTL and testbench

- Shares one downstream SRAM-like memory port between the IF-stage instruction port and the EXE/MEM-stage data port.
- Upstream the block looks like two independent SRAM-like slaves. Downstream it looks like one SRAM-like master.
- Tracks outstanding transactions in issue order and routes each data_ok/rdata back to the requester that issued it, so the MEM stage's data_ok-driven ready_go/buffer logic works unchanged.

---
 rtl/cpu_sram_arbiter_if.sv | 23 ++
 rtl/cpu_sram_arbiter.sv | 129 ++++++++++++
 tb/tb_cpu_sram_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sram_arbiter_if.sv
// SRAM-like request/response bundle shared by the CPU instruction port, the
// CPU data port and the downstream memory port of cpu_sram_arbiter.
interface cpu_sram_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/cpu_sram_arbiter.sv
// Shares one SRAM-like memory port between the IF and EXE/MEM stages and routes
// in-order responses back to their issuer. Define CPU_ARB_ROUND_ROBIN_EN for
// round-robin arbitration instead of fixed data-over-instruction priority.
module cpu_sram_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int PTR_W       = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1
) (
  input  logic                clk,
  input  logic                reset,
  cpu_sram_arbiter_if.slave   inst_sram,
  cpu_sram_arbiter_if.slave   data_sram,
  cpu_sram_arbiter_if.master  mem
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic             lock_id;
  logic             order_q [OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             grant;
  logic             grant_req;
  logic             push;
  logic             pop;
  logic             head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (PTR_W+1)'(OUTSTANDING));
  assign head_id = order_q[rd_ptr];

`ifdef CPU_ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= 1'b0;
    else if (push)
      last_grant <= grant;
  end
`endif

  // A stalled request keeps its grant until accepted so the downstream fields stay stable.
  always_comb begin
    grant = lock_id;
    if (state == IDLE) begin
`ifdef CPU_ARB_ROUND_ROBIN_EN
      if (inst_sram.req && data_sram.req)
        grant = ~last_grant;
      else
        grant = data_sram.req;
`else
      grant = data_sram.req;
`endif
    end
  end

  assign grant_req = grant ? data_sram.req : inst_sram.req;

  assign mem.req   = grant_req && !full;
  assign mem.wr    = grant ? data_sram.wr    : inst_sram.wr;
  assign mem.size  = grant ? data_sram.size  : inst_sram.size;
  assign mem.wstrb = grant ? data_sram.wstrb : inst_sram.wstrb;
  assign mem.addr  = grant ? data_sram.addr  : inst_sram.addr;
  assign mem.wdata = grant ? data_sram.wdata : inst_sram.wdata;

  assign push = mem.req && mem.addr_ok;
  assign pop  = mem.data_ok && (count != '0);

  assign inst_sram.addr_ok = push && !grant;
  assign data_sram.addr_ok = push && grant;

  // Responses with no outstanding id are dropped.
  assign inst_sram.data_ok = pop && !head_id;
  assign data_sram.data_ok = pop && head_id;
  assign inst_sram.rdata   = mem.rdata;
  assign data_sram.rdata   = mem.rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lock_id <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem.req && !mem.addr_ok) begin
            state   <= LOCKED;
            lock_id <= grant;
          end
        end
        LOCKED: begin
          if (!grant_req || push)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      order_q[wr_ptr] <= grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Self-checking bench for cpu_sram_arbiter: directed request/response sequences
// with a response scoreboard keyed by issuing port.
module tb_cpu_sram_arbiter;

  logic clk;
  logic reset;

  cpu_sram_arbiter_if inst_if ();
  cpu_sram_arbiter_if data_if ();
  cpu_sram_arbiter_if mem_if ();

  cpu_sram_arbiter #(.OUTSTANDING(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .inst_sram (inst_if),
    .data_sram (data_if),
    .mem       (mem_if)
  );

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic [31:0] daddr,
                               input logic aok, input logic dok, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    inst_if.req    = ireq;
    inst_if.addr   = iaddr;
    data_if.req    = dreq;
    data_if.addr   = daddr;
    mem_if.addr_ok = aok;
    mem_if.data_ok = dok;
    mem_if.rdata   = rdata;
  endtask

  task automatic expectGrant(input string tag, input logic req, input logic [31:0] addr,
                             input logic iok, input logic dok);
    @(negedge clk);
    checkOutput({tag, "_mem_req"}, 32'(mem_if.req), 32'(req));
    if (req)
      checkOutput({tag, "_mem_addr"}, mem_if.addr, addr);
    checkOutput({tag, "_inst_addr_ok"}, 32'(inst_if.addr_ok), 32'(iok));
    checkOutput({tag, "_data_addr_ok"}, 32'(data_if.addr_ok), 32'(dok));
  endtask

  task automatic expectPush(input logic port, input logic [31:0] rdata);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Every upstream response must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && (inst_if.data_ok || data_if.data_ok)) begin
      checkOutput("dual_data_ok", 32'(inst_if.data_ok && data_if.data_ok), 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("spurious_data_ok", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("resp_port", 32'(data_if.data_ok), 32'(e.port));
        checkOutput("resp_rdata", data_if.data_ok ? data_if.rdata : inst_if.rdata, e.rdata);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    inst_if.req    = 1'b0;
    inst_if.wr     = 1'b0;
    inst_if.size   = 2'd2;
    inst_if.wstrb  = 4'hf;
    inst_if.addr   = '0;
    inst_if.wdata  = '0;
    data_if.req    = 1'b0;
    data_if.wr     = 1'b0;
    data_if.size   = 2'd2;
    data_if.wstrb  = 4'hf;
    data_if.addr   = '0;
    data_if.wdata  = '0;
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
    mem_if.rdata   = '0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mem_req", 32'(mem_if.req), 32'd0);
    checkOutput("rst_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
    checkOutput("rst_data_data_ok", 32'(data_if.data_ok), 32'd0);

    // Single instruction read, returned two cycles after accept.
    applyStimulus(1, 32'h1c000000, 0, 0, 1, 0, 0);
    expectGrant("single", 1, 32'h1c000000, 1, 0);
    expectPush(0, 32'h02800c0c);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h02800c0c);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Simultaneous requests: data first, then instruction.
    applyStimulus(1, 32'h1c000004, 1, 32'h1c008000, 1, 0, 0);
    expectGrant("simul_a", 1, 32'h1c008000, 0, 1);
    expectPush(1, 32'h000000ff);
    applyStimulus(1, 32'h1c000004, 0, 0, 1, 0, 0);
    expectGrant("simul_b", 1, 32'h1c000004, 1, 0);
    expectPush(0, 32'h11112222);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h000000ff);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h11112222);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Data request stalled three cycles while the instruction port asks too.
    applyStimulus(0, 0, 1, 32'h1c008010, 0, 0, 0);
    expectGrant("dlock0", 1, 32'h1c008010, 0, 0);
    for (int i = 1; i < 3; i++) begin
      applyStimulus(1, 32'h1c000008, 1, 32'h1c008010, 0, 0, 0);
      expectGrant("dlock_wait", 1, 32'h1c008010, 0, 0);
    end
    applyStimulus(1, 32'h1c000008, 1, 32'h1c008010, 1, 0, 0);
    expectGrant("dlock_acc", 1, 32'h1c008010, 0, 1);
    expectPush(1, 32'haaaa0001);
    applyStimulus(1, 32'h1c000008, 0, 0, 1, 0, 0);
    expectGrant("dlock_next", 1, 32'h1c000008, 1, 0);
    expectPush(0, 32'hbbbb0002);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'haaaa0001);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hbbbb0002);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Instruction request stalled while the higher-priority data port asks.
    applyStimulus(1, 32'h1c000020, 0, 0, 0, 0, 0);
    expectGrant("ilock0", 1, 32'h1c000020, 0, 0);
    for (int i = 1; i < 3; i++) begin
      applyStimulus(1, 32'h1c000020, 1, 32'h1c008020, 0, 0, 0);
      expectGrant("ilock_wait", 1, 32'h1c000020, 0, 0);
    end
    applyStimulus(1, 32'h1c000020, 1, 32'h1c008020, 1, 0, 0);
    expectGrant("ilock_acc", 1, 32'h1c000020, 1, 0);
    expectPush(0, 32'hcccc0003);
    applyStimulus(0, 0, 1, 32'h1c008020, 1, 0, 0);
    expectGrant("ilock_next", 1, 32'h1c008020, 0, 1);
    expectPush(1, 32'hdddd0004);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hcccc0003);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hdddd0004);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Full order FIFO blocks issue; pop frees a slot only for the next cycle.
    applyStimulus(1, 32'h1c000010, 0, 0, 1, 0, 0);
    expectGrant("full_a", 1, 32'h1c000010, 1, 0);
    expectPush(0, 32'h0000a001);
    applyStimulus(1, 32'h1c000014, 0, 0, 1, 0, 0);
    expectGrant("full_b", 1, 32'h1c000014, 1, 0);
    expectPush(0, 32'h0000a002);
    applyStimulus(1, 32'h1c000018, 0, 0, 1, 0, 0);
    expectGrant("full_blk", 0, 0, 0, 0);
    applyStimulus(1, 32'h1c000018, 0, 0, 1, 1, 32'h0000a001);
    expectGrant("full_blk_pop", 0, 0, 0, 0);
    applyStimulus(1, 32'h1c000018, 0, 0, 1, 1, 32'h0000a002);
    expectGrant("full_pushpop", 1, 32'h1c000018, 1, 0);
    expectPush(0, 32'h0000a003);
    applyStimulus(1, 32'h1c00001c, 0, 0, 1, 0, 0);
    expectGrant("full_cnt1", 1, 32'h1c00001c, 1, 0);
    expectPush(0, 32'h0000a004);
    applyStimulus(1, 32'h1c000020, 0, 0, 1, 0, 0);
    expectGrant("full_again", 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000a003);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000a004);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Alternating back-to-back reads, each returned one cycle after accept.
    for (int k = 0; k < 6; k++) begin
      logic ip;
      logic dp;
      ip = (k < 5) && (k % 2 == 0);
      dp = (k < 5) && (k % 2 == 1);
      applyStimulus(ip, 32'h1c000100 + 32'(k * 4), dp, 32'h1c008100 + 32'(k * 4), 1,
                    k > 0, 32'hc0de0000 + 32'(k - 1));
      if (k < 5) begin
        expectGrant("wrap", 1, dp ? 32'h1c008100 + 32'(k * 4) : 32'h1c000100 + 32'(k * 4), ip, dp);
        expectPush(dp, 32'hc0de0000 + 32'(k));
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Reset with two reads outstanding discards them.
    applyStimulus(1, 32'h1c000200, 0, 0, 1, 0, 0);
    applyStimulus(1, 32'h1c000204, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    expectGrant("rst_mid", 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h5a5a5a5a);
    @(negedge clk);
    checkOutput("stray_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
    checkOutput("stray_data_data_ok", 32'(data_if.data_ok), 32'd0);
    applyStimulus(1, 32'h1c000208, 0, 0, 0, 0, 0);
    expectGrant("rst_cnt0", 1, 32'h1c000208, 0, 0);
    applyStimulus(0, 0, 1, 32'h1c008200, 1, 0, 0);
    expectGrant("lock_drop", 0, 0, 0, 0);

    // Data write passes its fields through and returns on the data port.
    applyStimulus(0, 0, 1, 32'h1c008204, 1, 0, 0);
    data_if.wr    = 1'b1;
    data_if.size  = 2'd1;
    data_if.wstrb = 4'b0011;
    data_if.wdata = 32'hdeadbeef;
    expectGrant("write", 1, 32'h1c008204, 0, 1);
    checkOutput("write_wr", 32'(mem_if.wr), 32'd1);
    checkOutput("write_size", 32'(mem_if.size), 32'd1);
    checkOutput("write_wstrb", 32'(mem_if.wstrb), 32'h3);
    checkOutput("write_wdata", mem_if.wdata, 32'hdeadbeef);
    expectPush(1, 32'h00000000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    data_if.wr    = 1'b0;
    data_if.size  = 2'd2;
    data_if.wstrb = 4'hf;
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h00000000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
